ring_slot_allocator: RTL and testbench
======================================

# ring_slot_allocator

Parametrised occupancy tracker and free-slot allocator for a ring-router input buffer of BUFFER_SIZE packet slots. It keeps a registered occupancy bitmap, accepts one allocation and one release per cycle, and advertises the next free slot as a registered pointer, using either fixed-priority or round-robin selection. It sits between the ring link receiver, which allocates a slot on packet arrival, and the output arbiter, which releases a slot on packet departure. It replaces the fixed 4-slot combinational empty-slot finder.

## Interface
Parameters:
- BUFFER_SIZE, 4, number of slots; legal range 2..64.
- PTR_LEN, $clog2(BUFFER_SIZE), slot pointer width.
- RR_MODE, 0. 0 selects the lowest free index. 1 searches round-robin, starting at the slot after the last allocated slot.

Ports:
- clk  in  1  clock; every register updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- alloc_req  in  1  claim the slot advertised on empty_pos this cycle.
- free_req  in  1  release slot free_pos this cycle.
- free_pos  in  PTR_LEN  slot to release.
- empty_pos  out  PTR_LEN  registered; the next slot to allocate.
- empty_pos_valid  out  1  registered; at least one slot is free.
- occupancy  out  BUFFER_SIZE  registered bitmap; bit i = 1 means slot i holds a packet.
- count  out  PTR_LEN+1  registered population count of occupancy.
- full  out  1  registered; count == BUFFER_SIZE.
- empty  out  1  registered; count == 0.
- err  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- Allocation:
  - An allocation is accepted when alloc_req=1 and empty_pos_valid=1.
  - On acceptance, occupancy[empty_pos] is set next cycle.
- Release:
  - A release is accepted when free_req=1 and occupancy[free_pos]=1.
  - On acceptance, occupancy[free_pos] is cleared next cycle.
- Accepted allocation and release in the same cycle:
  - Both take effect and count is unchanged.
  - They cannot target the same slot, because the advertised slot is always free.
- Protocol errors set err and change no state:
  - alloc_req=1 while empty_pos_valid=0.
  - free_req=1 on a slot that is already free.
  - free_pos >= BUFFER_SIZE.
- Selection of empty_pos:
  - Computed from the next-state occupancy and registered.
  - RR_MODE=0: the lowest free index wins.
  - RR_MODE=1: the search starts at last_alloc+1, modulo BUFFER_SIZE, and wraps through BUFFER_SIZE-1 back to 0.
  - last_alloc is an internal register, reset to BUFFER_SIZE-1, and updates only on an accepted allocation.
- No free slot: empty_pos_valid=0 and empty_pos=0.
- Count arithmetic:
  - count_next = count + alloc_acc - free_acc, held at PTR_LEN+1 bits.
  - count never wraps under legal use; the error cases above guarantee this.
- full and empty are registered from count_next, not decoded from the count output.

## Timing
- Reset values: occupancy=0, count=0, empty=1, full=0, empty_pos=0, empty_pos_valid=1, err=0.
  - In RR_MODE=1, last_alloc resets to BUFFER_SIZE-1, so the first advertised slot is 0.
- Reset mid-operation: all state returns to the reset values on the next edge and in-flight requests are dropped.
  - The block is usable in the first cycle after rst_n returns high.
- Allocation latency: alloc_req accepted in cycle N → occupancy bit set, count updated, and a new empty_pos shown in cycle N+1.
  - Back-to-back allocations, one per cycle, are legal.
- Release latency: free_req in cycle N → the slot is visible as free, and eligible for empty_pos, in cycle N+1.
- Full boundary:
  - Allocating the last free slot in cycle N gives full=1 and empty_pos_valid=0 in N+1.
  - A simultaneous allocate and release while full is not possible, because allocation needs empty_pos_valid=1.
  - Release-only while full gives empty_pos = the freed slot in N+1.
- Release of the last occupied slot gives empty=1 next cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package ring_buf_pkg holds:
  - the RR_MODE constants RR_PRIORITY=0 and RR_ROUND=1;
  - a ptr_len(size) function;
  - the slot-pointer and count typedefs, which other ring-router blocks share.
- Sub-module ring_slot_pick is a combinational find-first-zero over a bitmap with a start index and wrap.
  - It returns the position and a valid flag.
  - Priority mode uses start index 0.
- The top level holds the occupancy, count, last_alloc and err registers, acceptance decode, and output registers.

## Test plan
- Reset, then release rst_n → occupancy=0, count=0, empty=1, empty_pos=0, empty_pos_valid=1, err=0.
- BUFFER_SIZE=4, RR_MODE=0: four back-to-back allocations → empty_pos sequence 0,1,2,3; then full=1, empty_pos_valid=0, count=4, occupancy=4'b1111.
- From full, free slot 2 then slot 0 on consecutive cycles → empty_pos=2 after the first release and 0 after the second; count goes 3, then 2.
- RR_MODE=1, BUFFER_SIZE=8: allocate slots 0 and 1, free slot 0, then allocate → the third slot allocated is 2, not 0. Fill up to slot 7 → wraps and allocates 0.
- Same-cycle alloc (empty_pos=1) and free_pos=0 with occupancy=8'b0000_0001 → next cycle occupancy=8'b0000_0010, count=1.
- Free an already-free slot, and alloc_req while full → err=1 and sticks, occupancy unchanged. Assert rst_n=0 mid-stream → all outputs return to the reset values on the next edge.

Source files
------------

// File: rtl/ring_buf_pkg.sv
// Shared definitions for the ring-router buffer blocks: selection-mode
// constants, pointer-width helper and the common slot/count types.
package ring_buf_pkg;

  localparam int RR_PRIORITY = 0;
  localparam int RR_ROUND    = 1;

  localparam int MAX_BUFFER_SIZE = 64;

  // Pointer width needed to address 'size' slots (never narrower than 1 bit).
  function automatic int ptr_len(input int size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

  localparam int MAX_PTR_LEN = ptr_len(MAX_BUFFER_SIZE);

  typedef logic [MAX_PTR_LEN-1:0] slot_ptr_t;
  typedef logic [MAX_PTR_LEN:0]   slot_cnt_t;

endpackage

// File: rtl/ring_slot_pick.sv
// Combinational find-first-zero over a slot bitmap. The search begins at
// start_i and wraps from N-1 back to 0; a zero start gives plain
// lowest-index priority.
module ring_slot_pick
  import ring_buf_pkg::*;
#(
  parameter int N = 4,
  parameter int W = ptr_len(N)
) (
  input  logic [N-1:0] bitmap_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] pos_o,
  output logic         valid_o
);

  // Walk the ring from the start index; the first clear bit wins.
  always_comb begin
    logic [W:0] idx;
    pos_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, start_i} + (W+1)'(i);
      if (idx >= (W+1)'(N)) begin
        idx = idx - (W+1)'(N);
      end
      if (!valid_o && !bitmap_i[idx[W-1:0]]) begin
        valid_o = 1'b1;
        pos_o   = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/ring_slot_allocator.sv
// Occupancy tracker and free-slot allocator for the ring-router input
// buffer. One allocation and one release per cycle; the next free slot is
// advertised as a registered pointer chosen by fixed priority or round-robin.
module ring_slot_allocator
  import ring_buf_pkg::*;
#(
  parameter int BUFFER_SIZE = 4,
  parameter int PTR_LEN     = $clog2(BUFFER_SIZE),
  parameter int RR_MODE     = RR_PRIORITY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_req,
  input  logic                   free_req,
  input  logic [PTR_LEN-1:0]     free_pos,
  output logic [PTR_LEN-1:0]     empty_pos,
  output logic                   empty_pos_valid,
  output logic [BUFFER_SIZE-1:0] occupancy,
  output logic [PTR_LEN:0]       count,
  output logic                   full,
  output logic                   empty,
  output logic                   err
);

  localparam logic [PTR_LEN-1:0] LAST_SLOT = PTR_LEN'(BUFFER_SIZE - 1);
  localparam logic [PTR_LEN:0]   SIZE_CNT  = (PTR_LEN+1)'(BUFFER_SIZE);

  logic [BUFFER_SIZE-1:0] occ_q, occ_d;
  logic [PTR_LEN:0]       count_q, count_d;
  logic [PTR_LEN-1:0]     last_alloc_q, last_alloc_d;
  logic                   err_q, err_d;
  logic [PTR_LEN-1:0]     empty_pos_q, empty_pos_d;
  logic                   empty_pos_valid_q, empty_pos_valid_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;

  logic                   free_in_range;
  logic                   free_slot_busy;
  logic                   alloc_acc;
  logic                   free_acc;
  logic [PTR_LEN-1:0]     search_start;
  logic [PTR_LEN-1:0]     pick_pos;
  logic                   pick_valid;

  // Acceptance decode: a request only counts when it targets a legal slot.
  always_comb begin
    free_in_range  = ({1'b0, free_pos} < SIZE_CNT);
    free_slot_busy = free_in_range && occ_q[free_pos];
    alloc_acc      = alloc_req && empty_pos_valid_q;
    free_acc       = free_req && free_slot_busy;
  end

  // Next-state bookkeeping; rejected requests leave all state untouched
  // apart from the sticky error flag.
  always_comb begin
    occ_d = occ_q;
    if (alloc_acc) begin
      occ_d[empty_pos_q] = 1'b1;
    end
    if (free_acc) begin
      occ_d[free_pos] = 1'b0;
    end
    count_d      = count_q + (PTR_LEN+1)'(alloc_acc) - (PTR_LEN+1)'(free_acc);
    last_alloc_d = alloc_acc ? empty_pos_q : last_alloc_q;
    err_d        = err_q
                 | (alloc_req && !empty_pos_valid_q)
                 | (free_req && !free_slot_busy);
  end

  // Search origin: slot after the most recent allocation in round-robin mode.
  always_comb begin
    search_start = '0;
    if (RR_MODE == RR_ROUND) begin
      search_start = (last_alloc_d == LAST_SLOT) ? '0 : last_alloc_d + PTR_LEN'(1);
    end
  end

  ring_slot_pick #(
    .N (BUFFER_SIZE),
    .W (PTR_LEN)
  ) u_pick (
    .bitmap_i (occ_d),
    .start_i  (search_start),
    .pos_o    (pick_pos),
    .valid_o  (pick_valid)
  );

  // Output values derived from next-state occupancy and count.
  always_comb begin
    empty_pos_valid_d = pick_valid;
    empty_pos_d       = pick_valid ? pick_pos : '0;
    full_d            = (count_d == SIZE_CNT);
    empty_d           = (count_d == '0);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q             <= '0;
      count_q           <= '0;
      last_alloc_q      <= LAST_SLOT;
      err_q             <= 1'b0;
      empty_pos_q       <= '0;
      empty_pos_valid_q <= 1'b1;
      full_q            <= 1'b0;
      empty_q           <= 1'b1;
    end else begin
      occ_q             <= occ_d;
      count_q           <= count_d;
      last_alloc_q      <= last_alloc_d;
      err_q             <= err_d;
      empty_pos_q       <= empty_pos_d;
      empty_pos_valid_q <= empty_pos_valid_d;
      full_q            <= full_d;
      empty_q           <= empty_d;
    end
  end

  assign occupancy       = occ_q;
  assign count           = count_q;
  assign err             = err_q;
  assign empty_pos       = empty_pos_q;
  assign empty_pos_valid = empty_pos_valid_q;
  assign full            = full_q;
  assign empty           = empty_q;

endmodule

// File: tb/tb_ring_slot_allocator.sv
// Bench for ring_slot_allocator: a 4-slot priority instance and an 8-slot
// round-robin instance, directed vectors plus randomized traffic against a
// slot-list reference model.
module tb_ring_slot_allocator;
  import ring_buf_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0: BUFFER_SIZE=4, priority
  logic       a0, f0;
  logic [1:0] fp0, ep0;
  logic       v0, fu0, em0, er0;
  logic [3:0] oc0;
  logic [2:0] cn0;
  // Instance 1: BUFFER_SIZE=8, round-robin
  logic       a1, f1;
  logic [2:0] fp1, ep1;
  logic       v1, fu1, em1, er1;
  logic [7:0] oc1;
  logic [3:0] cn1;

  ring_slot_allocator #(.BUFFER_SIZE(4), .RR_MODE(RR_PRIORITY)) dut0 (
    .clk(clk), .rst_n(rst_n), .alloc_req(a0), .free_req(f0), .free_pos(fp0),
    .empty_pos(ep0), .empty_pos_valid(v0), .occupancy(oc0), .count(cn0),
    .full(fu0), .empty(em0), .err(er0));

  ring_slot_allocator #(.BUFFER_SIZE(8), .RR_MODE(RR_ROUND)) dut1 (
    .clk(clk), .rst_n(rst_n), .alloc_req(a1), .free_req(f1), .free_pos(fp1),
    .empty_pos(ep1), .empty_pos_valid(v1), .occupancy(oc1), .count(cn1),
    .full(fu1), .empty(em1), .err(er1));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: slot list per instance
  int       m_size[2] = '{4, 8};
  bit       m_rr[2]   = '{1'b0, 1'b1};
  bit       m_occ[2][8];
  int       m_last[2];
  int       m_pos[2];
  bit       m_vld[2];
  bit       m_err[2];

  function automatic int m_count(int d);
    int c = 0;
    for (int s = 0; s < 8; s++) if (m_occ[d][s]) c++;
    return c;
  endfunction

  function automatic int m_occ_vec(int d);
    int v = 0;
    for (int s = 0; s < 8; s++) if (m_occ[d][s]) v |= (1 << s);
    return v;
  endfunction

  task automatic m_advertise(int d);
    int start;
    start = m_rr[d] ? (m_last[d] + 1) % m_size[d] : 0;
    m_vld[d] = 1'b0;
    m_pos[d] = 0;
    for (int k = 0; k < m_size[d]; k++) begin
      int s;
      s = (start + k) % m_size[d];
      if (!m_occ[d][s]) begin
        m_pos[d] = s;
        m_vld[d] = 1'b1;
        break;
      end
    end
  endtask

  task automatic m_reset(int d);
    for (int s = 0; s < 8; s++) m_occ[d][s] = 1'b0;
    m_last[d] = m_size[d] - 1;
    m_err[d]  = 1'b0;
    m_advertise(d);
  endtask

  task automatic m_step(int d, bit a, bit f, int fp);
    bit aa, fa;
    aa = a && m_vld[d];
    fa = f && (fp < m_size[d]) && m_occ[d][fp];
    if ((a && !m_vld[d]) || (f && !fa)) m_err[d] = 1'b1;
    if (aa) begin
      m_occ[d][m_pos[d]] = 1'b1;
      m_last[d] = m_pos[d];
    end
    if (fa) m_occ[d][fp] = 1'b0;
    m_advertise(d);
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic get_out(int d, output int epos, output int vld, output int occ,
                         output int cnt, output int fu, output int em, output int er);
    if (d == 0) begin
      epos = int'(ep0); vld = int'(v0); occ = int'(oc0); cnt = int'(cn0);
      fu = int'(fu0); em = int'(em0); er = int'(er0);
    end else begin
      epos = int'(ep1); vld = int'(v1); occ = int'(oc1); cnt = int'(cn1);
      fu = int'(fu1); em = int'(em1); er = int'(er1);
    end
  endtask

  // Compare one instance against explicit expectations
  task automatic expect_out(int d, string tag, int epos, int vld, int occ, int cnt, int er);
    int a_ep, a_v, a_oc, a_cn, a_fu, a_em, a_er;
    get_out(d, a_ep, a_v, a_oc, a_cn, a_fu, a_em, a_er);
    chk({tag, ".empty_pos"}, a_ep, epos);
    chk({tag, ".empty_pos_valid"}, a_v, vld);
    chk({tag, ".occupancy"}, a_oc, occ);
    chk({tag, ".count"}, a_cn, cnt);
    chk({tag, ".full"}, a_fu, int'(cnt == m_size[d]));
    chk({tag, ".empty"}, a_em, int'(cnt == 0));
    chk({tag, ".err"}, a_er, er);
  endtask

  task automatic check_model(int d, string tag);
    expect_out(d, tag, m_pos[d], int'(m_vld[d]), m_occ_vec(d), m_count(d), int'(m_err[d]));
  endtask

  task automatic idle();
    a0 = 1'b0; f0 = 1'b0; fp0 = '0;
    a1 = 1'b0; f1 = 1'b0; fp1 = '0;
  endtask

  // One clock edge; the model follows the same inputs
  task automatic tick();
    bit sa0, sf0, sa1, sf1, srst;
    int sfp0, sfp1;
    sa0 = a0; sf0 = f0; sfp0 = int'(fp0);
    sa1 = a1; sf1 = f1; sfp1 = int'(fp1);
    srst = rst_n;
    @(posedge clk);
    #1;
    if (!srst) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(0, sa0, sf0, sfp0);
      m_step(1, sa1, sf1, sfp1);
    end
  endtask

  typedef struct {
    bit a; bit f; int fp;
    int epos; int vld; int occ; int cnt; int er;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Priority-mode directed vectors for instance 0
    tbl[0] = '{1'b1, 1'b0, 0, 1, 1, 'h1, 1, 0};
    tbl[1] = '{1'b1, 1'b0, 0, 2, 1, 'h3, 2, 0};
    tbl[2] = '{1'b1, 1'b0, 0, 3, 1, 'h7, 3, 0};
    tbl[3] = '{1'b1, 1'b0, 0, 0, 0, 'hF, 4, 0};
    tbl[4] = '{1'b0, 1'b1, 2, 2, 1, 'hB, 3, 0};
    tbl[5] = '{1'b0, 1'b1, 0, 0, 1, 'hA, 2, 0};
    tbl[6] = '{1'b1, 1'b0, 0, 2, 1, 'hB, 3, 0};
    tbl[7] = '{1'b1, 1'b1, 1, 1, 1, 'hD, 3, 0};
    tbl[8] = '{1'b0, 1'b1, 1, 1, 1, 'hD, 3, 1};
    tbl[9] = '{1'b0, 1'b0, 0, 1, 1, 'hD, 3, 1};

    idle();
    rst_n = 1'b0;
    tick();
    tick();
    expect_out(0, "reset0", 0, 1, 0, 0, 0);
    expect_out(1, "reset1", 0, 1, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      a0 = tbl[i].a; f0 = tbl[i].f; fp0 = 2'(tbl[i].fp);
      tick();
      expect_out(0, $sformatf("vec%0d", i), tbl[i].epos, tbl[i].vld, tbl[i].occ,
                 tbl[i].cnt, tbl[i].er);
    end
    idle();

    // Round-robin sequence on instance 1
    a1 = 1'b1;
    tick();
    expect_out(1, "rr_a0", 1, 1, 'h01, 1, 0);
    a1 = 1'b1; f1 = 1'b1; fp1 = 3'd0;
    tick();
    expect_out(1, "rr_same_cycle", 2, 1, 'h02, 1, 0);
    f1 = 1'b0;
    tick();
    expect_out(1, "rr_third", 3, 1, 'h06, 2, 0);
    for (int k = 3; k < 8; k++) begin
      int occ_exp;
      occ_exp = 'h06;
      for (int j = 3; j <= k; j++) occ_exp |= (1 << j);
      tick();
      expect_out(1, $sformatf("rr_fill%0d", k), (k == 7) ? 0 : k + 1, 1, occ_exp, k, 0);
    end
    tick();
    expect_out(1, "rr_wrap_full", 0, 0, 'hFF, 8, 0);
    tick();
    expect_out(1, "rr_alloc_full", 0, 0, 'hFF, 8, 1);
    a1 = 1'b0; f1 = 1'b1; fp1 = 3'd5;
    tick();
    expect_out(1, "rr_free_full", 5, 1, 'hDF, 7, 1);
    f1 = 1'b0; a1 = 1'b1; a0 = 1'b1;
    rst_n = 1'b0;
    tick();
    expect_out(0, "midrst0", 0, 1, 0, 0, 0);
    expect_out(1, "midrst1", 0, 1, 0, 0, 0);
    rst_n = 1'b1;
    a0 = 1'b0;
    tick();
    expect_out(1, "post_rst", 1, 1, 'h01, 1, 0);
    idle();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      a0 = 1'($urandom); f0 = 1'($urandom); fp0 = 2'($urandom);
      a1 = 1'($urandom); f1 = 1'($urandom); fp1 = 3'($urandom);
      tick();
      check_model(0, "rand0");
      check_model(1, "rand1");
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
